// File: rtl/ysyx_22040237_wb_sched.sv
// Write-back scheduler: two buffered producers (ALU, LSU) share the single GPR write port,
// with a per-GPR pending-write scoreboard for decode RAW/WAW stalls.

// Generic single-clock FIFO buffering one write-back producer.
// Latency: an entry pushed at edge N is at the head during the cycle after edge N.
// Backpressure: full_o depends only on the stored count; a push is dropped while full.
module ysyx_22040237_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 69
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (cnt_q == FULL_CNT);
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so plain increment wraps the pointers modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// Round-robin write-back scheduler in front of the GPR write port, plus pending-write scoreboard.
// Latency: uncontended request accepted at edge N drives rd_wr_en_o during cycle N+1..N+2.
// Backpressure: alu/lsu_ready_o = FIFO not full; iss_ready_o = 0 while the target counter is saturated.
module ysyx_22040237_wb_sched #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid_i,
    output logic        alu_ready_o,
    input  logic [4:0]  alu_rd_idx_i,
    input  logic [63:0] alu_data_i,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_idx_i,
    input  logic [63:0] lsu_data_i,
    input  logic        iss_valid_i,
    input  logic [4:0]  iss_rd_idx_i,
    output logic        iss_ready_o,
    output logic        rd_wr_en_o,
    output logic [4:0]  rd_wr_idx_o,
    output logic [63:0] rd_wr_data_o,
    output logic [31:0] busy_o
);
    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] dat;
    } wb_req_t;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_req_t alu_push_dat, lsu_push_dat;
    wb_req_t alu_head, lsu_head, gnt_req;
    logic    alu_full, alu_empty;
    logic    lsu_full, lsu_empty;
    logic    alu_gnt, lsu_gnt;
    rr_e     rr_q, rr_d;

    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_idx_q, wr_idx_d;
    logic [63:0] wr_dat_q, wr_dat_d;

    logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]            inc_vec, dec_vec;

    assign alu_push_dat = '{idx: alu_rd_idx_i, dat: alu_data_i};
    assign lsu_push_dat = '{idx: lsu_rd_idx_i, dat: lsu_data_i};
    assign alu_ready_o  = !alu_full;
    assign lsu_ready_o  = !lsu_full;

    ysyx_22040237_wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_req_t))) u_alu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (alu_valid_i),
        .push_dat_i (alu_push_dat),
        .pop_i      (alu_gnt),
        .head_dat_o (alu_head),
        .full_o     (alu_full),
        .empty_o    (alu_empty)
    );

    ysyx_22040237_wb_fifo #(.DEPTH(DEPTH), .W($bits(wb_req_t))) u_lsu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (lsu_valid_i),
        .push_dat_i (lsu_push_dat),
        .pop_i      (lsu_gnt),
        .head_dat_o (lsu_head),
        .full_o     (lsu_full),
        .empty_o    (lsu_empty)
    );

    // The rr pointer only advances when both producers compete.
    always_comb begin
        alu_gnt = 1'b0;
        lsu_gnt = 1'b0;
        rr_d    = rr_q;
        if (!alu_empty && !lsu_empty) begin
            if (rr_q == RR_LSU) begin
                lsu_gnt = 1'b1;
                rr_d    = RR_ALU;
            end else begin
                alu_gnt = 1'b1;
                rr_d    = RR_LSU;
            end
        end else if (!alu_empty) begin
            alu_gnt = 1'b1;
        end else if (!lsu_empty) begin
            lsu_gnt = 1'b1;
        end
    end

    assign gnt_req = alu_gnt ? alu_head : lsu_head;

    // x0 targets are still popped and loaded, but never enabled.
    always_comb begin
        wr_en_d  = 1'b0;
        wr_idx_d = wr_idx_q;
        wr_dat_d = wr_dat_q;
        if (alu_gnt || lsu_gnt) begin
            wr_en_d  = (gnt_req.idx != 5'd0);
            wr_idx_d = gnt_req.idx;
            wr_dat_d = gnt_req.dat;
        end
    end

    assign iss_ready_o = (iss_rd_idx_i == 5'd0) || (cnt_q[iss_rd_idx_i] != CNT_MAX);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (iss_valid_i && iss_ready_o) inc_vec[iss_rd_idx_i] = 1'b1;
        if (wr_en_q)                    dec_vec[wr_idx_q]     = 1'b1;
        inc_vec[0] = 1'b0;
        dec_vec[0] = 1'b0;
    end

    // Decrement is the same edge the regfile captures the write; underflow is clamped.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 1; i < 32; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy_o = '0;
        for (int i = 1; i < 32; i++) busy_o[i] = (cnt_q[i] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q     <= RR_LSU;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
            wr_dat_q <= '0;
            cnt_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
            wr_dat_q <= wr_dat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_wr_en_o   = wr_en_q;
    assign rd_wr_idx_o  = wr_idx_q;
    assign rd_wr_data_o = wr_dat_q;
endmodule

// File: tb/tb_ysyx_22040237_wb_sched.sv
// Scoreboard bench for the write-back scheduler; LSU data is tagged with bit 63 = 1,
// ALU data with bit 63 = 0, so each write can be matched to its producer queue.
module tb_ysyx_22040237_wb_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_idx_i = '0;
    logic [63:0] alu_data_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_idx_i = '0;
    logic [63:0] lsu_data_i = '0;
    logic        iss_valid_i = 1'b0;
    logic [4:0]  iss_rd_idx_i = '0;
    logic        iss_ready_o;
    logic        rd_wr_en_o;
    logic [4:0]  rd_wr_idx_o;
    logic [63:0] rd_wr_data_o;
    logic [31:0] busy_o;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] dat;
    } ent_t;

    localparam logic [63:0] LSU_TAG = 64'h8000_0000_0000_0000;

    ent_t alu_q[$];
    ent_t lsu_q[$];
    bit   obs_src[$];
    int   mcnt[32];
    int   total = 0;
    int   bad = 0;

    ent_t        m_ent;
    logic [31:0] m_busy;
    logic        m_irdy;

    ysyx_22040237_wb_sched u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rd_idx_i (alu_rd_idx_i),
        .alu_data_i   (alu_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_idx_i (lsu_rd_idx_i),
        .lsu_data_i   (lsu_data_i),
        .iss_valid_i  (iss_valid_i),
        .iss_rd_idx_i (iss_rd_idx_i),
        .iss_ready_o  (iss_ready_o),
        .rd_wr_en_o   (rd_wr_en_o),
        .rd_wr_idx_o  (rd_wr_idx_o),
        .rd_wr_data_o (rd_wr_data_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Scoreboard and pending-write model, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            alu_q.delete();
            lsu_q.delete();
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
        end else begin
            m_busy = '0;
            for (int i = 1; i < 32; i++) m_busy[i] = (mcnt[i] != 0);
            total++;
            if (busy_o !== m_busy) begin
                bad++;
                $display("FAIL busy_model: got %h want %h at %0t", busy_o, m_busy, $time);
            end
            m_irdy = (iss_rd_idx_i == 5'd0) || (mcnt[iss_rd_idx_i] != 3);
            total++;
            if (iss_ready_o !== m_irdy) begin
                bad++;
                $display("FAIL iss_ready_model: got %b want %b at %0t", iss_ready_o, m_irdy, $time);
            end
            if (rd_wr_en_o === 1'b1) begin
                obs_src.push_back(rd_wr_data_o[63]);
                total++;
                if ((rd_wr_data_o[63] ? lsu_q.size() : alu_q.size()) == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got idx=%0d data=%h want none at %0t",
                             rd_wr_idx_o, rd_wr_data_o, $time);
                end else begin
                    m_ent = rd_wr_data_o[63] ? lsu_q.pop_front() : alu_q.pop_front();
                    if ({rd_wr_idx_o, rd_wr_data_o} !== m_ent) begin
                        bad++;
                        $display("FAIL write_data: got idx=%0d data=%h want idx=%0d data=%h",
                                 rd_wr_idx_o, rd_wr_data_o, m_ent.idx, m_ent.dat);
                    end
                end
                total++;
                if (mcnt[rd_wr_idx_o] == 0) begin
                    bad++;
                    $display("FAIL dec_at_zero: got count 0 want >0 for idx=%0d", rd_wr_idx_o);
                end
            end
            if (iss_valid_i && m_irdy && iss_rd_idx_i != 5'd0) mcnt[iss_rd_idx_i]++;
            if (rd_wr_en_o === 1'b1 && rd_wr_idx_o != 5'd0 && mcnt[rd_wr_idx_o] > 0) mcnt[rd_wr_idx_o]--;
            if (alu_valid_i && alu_ready_o && alu_rd_idx_i != 5'd0) alu_q.push_back({alu_rd_idx_i, alu_data_i});
            if (lsu_valid_i && lsu_ready_o && lsu_rd_idx_i != 5'd0) lsu_q.push_back({lsu_rd_idx_i, lsu_data_i});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        alu_valid_i  = 1'b0;
        alu_rd_idx_i = '0;
        alu_data_i   = '0;
        lsu_valid_i  = 1'b0;
        lsu_rd_idx_i = '0;
        lsu_data_i   = '0;
        iss_valid_i  = 1'b0;
        iss_rd_idx_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(input logic [4:0] idx);
        iss_valid_i  = 1'b1;
        iss_rd_idx_i = idx;
        step();
        iss_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, busy_o} !== '0 ||
            {alu_ready_o, lsu_ready_o, iss_ready_o} !== 3'b111) begin
            bad++;
            $display("FAIL reset_state: got en=%b idx=%0d data=%h busy=%h rdy=%b%b%b want zeros/111",
                     rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, busy_o, alu_ready_o, lsu_ready_o, iss_ready_o);
        end
        do_reset();
        @(negedge clk);
        total++;
        if ({rd_wr_en_o, busy_o} !== '0 || {alu_ready_o, lsu_ready_o} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release: got en=%b busy=%h rdy=%b%b want 0/0/11",
                     rd_wr_en_o, busy_o, alu_ready_o, lsu_ready_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        issue(5'd5);
        alu_valid_i  = 1'b1;
        alu_rd_idx_i = 5'd5;
        alu_data_i   = 64'h1234;
        step();
        alu_valid_i  = 1'b0;
        @(negedge clk);
        total++;
        if (rd_wr_en_o !== 1'b0) begin
            bad++;
            $display("FAIL single_early: got en=%b want 0", rd_wr_en_o);
        end
        step();
        @(negedge clk);
        total++;
        if (rd_wr_en_o !== 1'b1 || rd_wr_idx_o !== 5'd5 || rd_wr_data_o !== 64'h1234 || busy_o[5] !== 1'b1) begin
            bad++;
            $display("FAIL single_write: got en=%b idx=%0d data=%h busy5=%b want 1/5/1234/1",
                     rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, busy_o[5]);
        end
        step();
        @(negedge clk);
        total++;
        if (busy_o[5] !== 1'b0 || rd_wr_en_o !== 1'b0) begin
            bad++;
            $display("FAIL single_busy_clear: got busy5=%b en=%b want 0/0", busy_o[5], rd_wr_en_o);
        end
    endtask

    task automatic test_round_robin();
        int na = 0;
        int nl = 0;
        int cyc = 0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(5'd1);
            issue(5'd2);
        end
        obs_src.delete();
        while ((na < 3 || nl < 3) && cyc < 30) begin
            alu_valid_i  = (na < 3);
            alu_rd_idx_i = 5'd1;
            alu_data_i   = 64'h100 + 64'(na);
            lsu_valid_i  = (nl < 3);
            lsu_rd_idx_i = 5'd2;
            lsu_data_i   = LSU_TAG + 64'h200 + 64'(nl);
            @(negedge clk);
            if (alu_valid_i && alu_ready_o) na++;
            if (lsu_valid_i && lsu_ready_o) nl++;
            step();
            cyc++;
        end
        clear_inputs();
        total++;
        if (cyc >= 30) begin
            bad++;
            $display("FAIL rr_timeout: got alu=%0d lsu=%0d accepted want 3/3", na, nl);
        end
        repeat (6) step();
        total++;
        if (obs_src.size() != 6) begin
            bad++;
            $display("FAIL rr_count: got %0d writes want 6", obs_src.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (obs_src[k] !== ((k % 2) == 0)) begin
                    bad++;
                    $display("FAIL rr_order: write %0d got lsu=%b want lsu=%b", k, obs_src[k], (k % 2) == 0);
                end
            end
        end
        total++;
        if (alu_q.size() != 0 || lsu_q.size() != 0) begin
            bad++;
            $display("FAIL rr_lost: got pending alu=%0d lsu=%0d want 0/0", alu_q.size(), lsu_q.size());
        end
    endtask

    task automatic test_lsu_stall();
        bit         av[6]   = '{1, 1, 0, 0, 0, 0};
        bit         lv[6]   = '{1, 0, 1, 1, 1, 1};
        logic [4:0] aidx[6] = '{3, 9, 0, 0, 0, 0};
        logic [4:0] lidx[6] = '{4, 0, 5, 6, 8, 8};
        bit         ear[6]  = '{1, 1, 0, 1, 1, 1};
        bit         elr[6]  = '{1, 1, 1, 1, 0, 1};
        do_reset();
        issue(5'd3); issue(5'd9); issue(5'd4);
        issue(5'd5); issue(5'd6); issue(5'd8);
        for (int c = 0; c < 6; c++) begin
            alu_valid_i  = av[c];
            alu_rd_idx_i = aidx[c];
            alu_data_i   = 64'h300 + 64'(aidx[c]);
            lsu_valid_i  = lv[c];
            lsu_rd_idx_i = lidx[c];
            lsu_data_i   = LSU_TAG + 64'h400 + 64'(lidx[c]);
            @(negedge clk);
            total++;
            if (alu_ready_o !== ear[c] || lsu_ready_o !== elr[c]) begin
                bad++;
                $display("FAIL stall_ready c%0d: got alu=%b lsu=%b want alu=%b lsu=%b",
                         c, alu_ready_o, lsu_ready_o, ear[c], elr[c]);
            end
            step();
        end
        clear_inputs();
        repeat (6) step();
        total++;
        if (alu_q.size() != 0 || lsu_q.size() != 0) begin
            bad++;
            $display("FAIL stall_lost: got pending alu=%0d lsu=%0d want 0/0", alu_q.size(), lsu_q.size());
        end
    endtask

    task automatic test_x0();
        do_reset();
        issue(5'd3);
        alu_valid_i  = 1'b1;
        alu_rd_idx_i = 5'd0;
        alu_data_i   = 64'hFFFF;
        step();
        alu_rd_idx_i = 5'd3;
        alu_data_i   = 64'h33;
        step();
        alu_valid_i  = 1'b0;
        @(negedge clk);
        total++;
        if (rd_wr_en_o !== 1'b0 || rd_wr_idx_o !== 5'd0 || rd_wr_data_o !== 64'hFFFF || busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL x0_drop: got en=%b idx=%0d data=%h busy0=%b want 0/0/ffff/0",
                     rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, busy_o[0]);
        end
        repeat (3) step();
        @(negedge clk);
        total++;
        if (rd_wr_en_o !== 1'b0 || rd_wr_idx_o !== 5'd3 || rd_wr_data_o !== 64'h33 || alu_q.size() != 0) begin
            bad++;
            $display("FAIL x0_hold: got en=%b idx=%0d data=%h pend=%0d want 0/3/33/0",
                     rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, alu_q.size());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (3) issue(5'd7);
        iss_valid_i  = 1'b1;
        iss_rd_idx_i = 5'd7;
        @(negedge clk);
        total++;
        if (iss_ready_o !== 1'b0 || busy_o[7] !== 1'b1) begin
            bad++;
            $display("FAIL sat_full: got iss_ready=%b busy7=%b want 0/1", iss_ready_o, busy_o[7]);
        end
        step();
        iss_valid_i  = 1'b0;
        alu_valid_i  = 1'b1;
        alu_rd_idx_i = 5'd7;
        alu_data_i   = 64'h71;
        step();
        alu_data_i   = 64'h72;
        step();
        alu_valid_i  = 1'b0;
        step();
        iss_valid_i  = 1'b1;
        iss_rd_idx_i = 5'd7;
        @(negedge clk);
        total++;
        if (iss_ready_o !== 1'b1 || rd_wr_en_o !== 1'b1 || rd_wr_idx_o !== 5'd7) begin
            bad++;
            $display("FAIL sat_same_cycle: got iss_ready=%b en=%b idx=%0d want 1/1/7",
                     iss_ready_o, rd_wr_en_o, rd_wr_idx_o);
        end
        step();
        iss_valid_i = 1'b0;
        @(negedge clk);
        total++;
        if (iss_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL sat_unchanged: got iss_ready=%b want 1", iss_ready_o);
        end
        issue(5'd7);
        iss_rd_idx_i = 5'd7;
        @(negedge clk);
        total++;
        if (iss_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL sat_refill: got iss_ready=%b want 0", iss_ready_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            issue(5'd10);
            issue(5'd11);
        end
        for (int k = 0; k < 3; k++) begin
            alu_valid_i  = 1'b1;
            alu_rd_idx_i = 5'd10;
            alu_data_i   = 64'hA00 + 64'(k);
            lsu_valid_i  = 1'b1;
            lsu_rd_idx_i = 5'd11;
            lsu_data_i   = LSU_TAG + 64'hB00 + 64'(k);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, busy_o} !== '0 || {alu_ready_o, lsu_ready_o} !== 2'b11) begin
            bad++;
            $display("FAIL async_clear: got en=%b idx=%0d data=%h busy=%h rdy=%b%b want zeros/11",
                     rd_wr_en_o, rd_wr_idx_o, rd_wr_data_o, busy_o, alu_ready_o, lsu_ready_o);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        obs_src.delete();
        repeat (5) step();
        @(negedge clk);
        total++;
        if (obs_src.size() != 0 || busy_o !== 32'h0 || rd_wr_en_o !== 1'b0) begin
            bad++;
            $display("FAIL stale_write: got writes=%0d busy=%h en=%b want 0/0/0",
                     obs_src.size(), busy_o, rd_wr_en_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lsu_stall();
        test_x0();
        test_saturate();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
